// File: rtl/cram_config_loader.sv
// rtl/cram_config_loader.sv - serialises bitstream words LSB-first onto the CRAM chain; optional CRC-8 check via CFG_CRC_EN
module cram_config_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 256,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              en,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              cfg_data,
   output logic              cfg_en,
   output logic              busy,
   output logic              done,
   output logic              crc_err
);

   localparam int RW = $clog2(WORD_W + 1);

`ifdef CFG_CRC_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

   state_t            state;
   logic [CNT_W-1:0]  bits_sent;
   logic [RW-1:0]     rem;
   logic [WORD_W-1:0] shreg;
   logic              ready_q;
   logic              cfg_en_q;
   logic              data_q;
   logic              busy_q;
   logic              done_q;

   logic [CNT_W-1:0]  bits_next;
   logic [CNT_W-1:0]  left_c;
   logic [RW-1:0]     first_n;

   // Bits still owed to the chain decide how many bits of the next word are real
   assign bits_next = bits_sent + CNT_W'(1);
   assign left_c    = CNT_W'(CHAIN_LEN) - bits_sent;
   assign first_n   = (32'(left_c) < 32'(WORD_W)) ? RW'(left_c) : RW'(WORD_W);

`ifdef CFG_CRC_EN
   logic [7:0] crc_q;
   logic [7:0] crc_next;
   logic       crc_err_q;
   logic       crc_fb;

   // Serial CRC-8 step over the bit currently on the chain
   assign crc_fb   = crc_q[7] ^ data_q;
   assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
   assign crc_err  = crc_err_q;
`else
   assign crc_err  = 1'b0;
`endif

   // Disabling freezes everything, so handshake and chain strobe are masked by en
   assign word_ready = ready_q & en;
   assign cfg_en     = cfg_en_q & en;
   assign cfg_data   = data_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // Load sequencer: state, counters, shift register and registered outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         bits_sent <= '0;
         rem       <= '0;
         shreg     <= '0;
         ready_q   <= 1'b0;
         cfg_en_q  <= 1'b0;
         data_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef CFG_CRC_EN
         crc_q     <= 8'h00;
         crc_err_q <= 1'b0;
`endif
      end else if (en) begin
         if (abort) begin
            state     <= S_IDLE;
            bits_sent <= '0;
            rem       <= '0;
            ready_q   <= 1'b0;
            cfg_en_q  <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CFG_CRC_EN
            crc_q     <= 8'h00;
            crc_err_q <= 1'b0;
`endif
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     state     <= S_LOAD;
                     bits_sent <= '0;
                     ready_q   <= 1'b1;
                     busy_q    <= 1'b1;
                     done_q    <= 1'b0;
`ifdef CFG_CRC_EN
                     crc_q     <= 8'h00;
                     crc_err_q <= 1'b0;
`endif
                  end
               end
               S_LOAD: begin
                  if (word_valid) begin
                     state    <= S_SHIFT;
                     ready_q  <= 1'b0;
                     cfg_en_q <= 1'b1;
                     data_q   <= word_data[0];
                     shreg    <= word_data >> 1;
                     rem      <= first_n;
                  end
               end
               S_SHIFT: begin
                  bits_sent <= bits_next;
`ifdef CFG_CRC_EN
                  crc_q     <= crc_next;
`endif
                  if (rem == RW'(1)) begin
                     cfg_en_q <= 1'b0;
                     data_q   <= 1'b0;
                     if (bits_next == CNT_W'(CHAIN_LEN)) begin
`ifdef CFG_CRC_EN
                        state   <= S_CHECK;
                        ready_q <= 1'b1;
`else
                        state   <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                     end else begin
                        state   <= S_LOAD;
                        ready_q <= 1'b1;
                     end
                  end else begin
                     data_q <= shreg[0];
                     shreg  <= shreg >> 1;
                     rem    <= rem - RW'(1);
                  end
               end
`ifdef CFG_CRC_EN
               S_CHECK: begin
                  if (word_valid) begin
                     crc_err_q <= (word_data[7:0] != crc_q);
                     state     <= S_DONE;
                     ready_q   <= 1'b0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end
`endif
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cram_config_loader.sv
// tb/tb_cram_config_loader.sv - self-checking bench for cram_config_loader
module tb_cram_config_loader;

`ifdef CFG_CRC_EN
   localparam int NDUT = 3;
`else
   localparam int NDUT = 2;
`endif

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0]      en_s    = '1;
   logic [NDUT-1:0]      start_s = '0;
   logic [NDUT-1:0]      abort_s = '0;
   logic [NDUT-1:0]      valid_s = '0;
   logic [NDUT-1:0][7:0] wdata_s = '0;
   logic [NDUT-1:0]      ready_s;
   logic [NDUT-1:0]      cdata_s;
   logic [NDUT-1:0]      cen_s;
   logic [NDUT-1:0]      busy_s;
   logic [NDUT-1:0]      done_s;
   logic [NDUT-1:0]      err_s;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int CL = (g == 0) ? 16 : (g == 1) ? 20 : 8;
      cram_config_loader #(.WORD_W(8), .CHAIN_LEN(CL)) dut (
         .clk       (clk),
         .nrst      (nrst),
         .en        (en_s[g]),
         .start     (start_s[g]),
         .abort     (abort_s[g]),
         .word_data (wdata_s[g]),
         .word_valid(valid_s[g]),
         .word_ready(ready_s[g]),
         .cfg_data  (cdata_s[g]),
         .cfg_en    (cen_s[g]),
         .busy      (busy_s[g]),
         .done      (done_s[g]),
         .crc_err   (err_s[g])
      );
   end

   // model state: pending words, expected chain bits, expected CRC verdict
   logic [7:0]  wq    [NDUT][$];
   bit          exp_q [NDUT][$];
   int          mcnt  [NDUT];
   logic [63:0] mbits [NDUT];
   logic        exp_err [NDUT];
   int          cnt_en  [NDUT];
   int          cnt_one [NDUT];
   int          first_cyc [NDUT];
   int          last_cyc  [NDUT];
   int          start_cyc [NDUT];
   logic [63:0] seq [NDUT];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [7:0]  drv_w;

   function automatic int cl_of(input int d);
      return (d == 0) ? 16 : (d == 1) ? 20 : 8;
   endfunction

   function automatic logic [7:0] crc_of(input logic [63:0] v, input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (c[7] ^ v[i]) c = {c[6:0], 1'b0} ^ 8'h07;
         else             c = {c[6:0], 1'b0};
      end
      return c;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_clear(input int d);
      exp_q[d].delete();
      mcnt[d]    = 0;
      mbits[d]   = '0;
      exp_err[d] = 1'b0;
   endtask

   // stream source + model update: a word is consumed on a ready&valid edge unless aborted
   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         if (!nrst) begin
            model_clear(d);
            wq[d].delete();
         end else if (en_s[d]) begin
            if (abort_s[d]) begin
               model_clear(d);
               wq[d].delete();
            end else begin
               if (start_s[d]) begin
                  model_clear(d);
                  cnt_en[d]  = 0;
                  cnt_one[d] = 0;
                  seq[d]     = '0;
               end
               if (valid_s[d] && ready_s[d] && wq[d].size() > 0) begin
                  drv_w = wq[d].pop_front();
                  if (mcnt[d] >= cl_of(d)) begin
                     exp_err[d] = (drv_w != crc_of(mbits[d], cl_of(d)));
                  end else begin
                     for (int i = 0; i < 8 && mcnt[d] < cl_of(d); i++) begin
                        exp_q[d].push_back(drv_w[i]);
                        mbits[d][mcnt[d]] = drv_w[i];
                        mcnt[d]++;
                     end
                  end
               end
            end
         end
      end
      #1;
      for (int d = 0; d < NDUT; d++) begin
         valid_s[d] = (wq[d].size() > 0);
         wdata_s[d] = (wq[d].size() > 0) ? wq[d][0] : 8'h00;
      end
   end

   // per-cycle compare of chain outputs against the model
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (!nrst) begin
            chk("reset_outputs",
                64'({ready_s[d], cdata_s[d], cen_s[d], busy_s[d], done_s[d], err_s[d]}), 64'd0);
         end else begin
            if (!en_s[d]) chk("cfg_en_while_disabled", 64'(cen_s[d]), 64'd0);
            if (cen_s[d]) begin
               chk("busy_with_cfg_en", 64'(busy_s[d]), 64'd1);
               chk("bit_expected", 64'(exp_q[d].size() > 0), 64'd1);
               if (exp_q[d].size() > 0) chk("cfg_data", 64'(cdata_s[d]), 64'(exp_q[d].pop_front()));
               if (cnt_en[d] == 0) first_cyc[d] = cyc;
               last_cyc[d] = cyc;
               if (cnt_en[d] < 64) seq[d][cnt_en[d]] = cdata_s[d];
               cnt_en[d]++;
               cnt_one[d] += int'(cdata_s[d]);
            end
            chk("busy_done_exclusive", 64'(busy_s[d] & done_s[d]), 64'd0);
         end
      end
   end

   task automatic push_words(input int d, input logic [23:0] packed_w, input int nw);
      for (int i = 0; i < nw; i++) wq[d].push_back(packed_w[i*8 +: 8]);
`ifdef CFG_CRC_EN
      wq[d].push_back(crc_of(64'(packed_w), cl_of(d)));
`endif
   endtask

   task automatic pulse_start(input int d);
      @(posedge clk); #2;
      start_s[d]   = 1'b1;
      start_cyc[d] = cyc;
      @(posedge clk); #2;
      start_s[d]   = 1'b0;
   endtask

   task automatic wait_bits(input int d, input int n);
      int k;
      k = 0;
      do begin @(posedge clk); #3; k++; end while (cnt_en[d] < n && k < 100);
      chk("bits_reached", 64'(cnt_en[d] >= n), 64'd1);
   endtask

   task automatic wait_done(input int d, output int done_cyc);
      int k;
      k = 0;
      do begin @(posedge clk); #3; k++; end while (!done_s[d] && k < 120);
      done_cyc = cyc;
      chk("done_reached", 64'(done_s[d]), 64'd1);
      chk("busy_at_done", 64'(busy_s[d]), 64'd0);
      chk("bit_count", 64'(cnt_en[d]), 64'(cl_of(d)));
      chk("bits_outstanding", 64'(exp_q[d].size()), 64'd0);
      chk("crc_err", 64'(err_s[d]), 64'(exp_err[d]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      repeat (3) @(posedge clk);
      #2 nrst = 1'b1;

      // 1: two full words on a 16-bit chain
      push_words(0, 24'h003CA5, 2);
      pulse_start(0);
      wait_done(0, dc);
      chk("t1_sequence", 64'(seq[0][15:0]), 64'h0000_0000_0000_3CA5);
      chk("t1_ones", 64'(cnt_one[0]), 64'd8);
      chk("t1_first_latency", 64'(first_cyc[0] - start_cyc[0]), 64'd2);
      chk("t1_span_one_bubble", 64'(last_cyc[0] - first_cyc[0]), 64'd16);
`ifdef CFG_CRC_EN
      chk("t1_done_after_last", 64'(dc - last_cyc[0]), 64'd2);
`else
      chk("t1_done_after_last", 64'(dc - last_cyc[0]), 64'd1);
`endif

      // 2: partial final word on a 20-bit chain
      push_words(1, 24'hFF0000, 3);
      pulse_start(1);
      wait_done(1, dc);
      chk("t2_ones", 64'(cnt_one[1]), 64'd4);
      chk("t2_sequence", 64'(seq[1][19:0]), 64'h0000_0000_000F_0000);

      // 3: enable gap after four bits
      push_words(0, 24'h003CA5, 2);
      pulse_start(0);
      wait_bits(0, 4);
      en_s[0] = 1'b0;
      repeat (3) @(posedge clk);
      #3 en_s[0] = 1'b1;
      wait_done(0, dc);
      chk("t3_resumed_bits", 64'(seq[0][7:4]), 64'h0000_0000_0000_000A);

      // 4: abort mid-shift, abort beating a handshake, then a clean reload
      push_words(1, 24'h0FC35A, 3);
      pulse_start(1);
      wait_bits(1, 5);
      abort_s[1] = 1'b1;
      @(posedge clk); #2;
      abort_s[1] = 1'b0;
      chk("t4_abort_state",
          64'({cen_s[1], busy_s[1], done_s[1], ready_s[1]}), 64'd0);
      push_words(1, 24'h0FC35A, 3);
      pulse_start(1);
      chk("t4_ready_in_load", 64'(ready_s[1] & valid_s[1]), 64'd1);
      abort_s[1] = 1'b1;
      @(posedge clk); #2;
      abort_s[1] = 1'b0;
      chk("t4_abort_over_handshake", 64'({cen_s[1], busy_s[1], ready_s[1]}), 64'd0);
      @(posedge clk); #2;
      chk("t4_no_late_shift", 64'(cen_s[1]), 64'd0);
      push_words(1, 24'h0FC35A, 3);
      pulse_start(1);
      chk("t4_restart_ready", 64'(ready_s[1]), 64'd1);
      wait_done(1, dc);
      chk("t4_sequence", 64'(seq[1][19:0]), 64'h0000_0000_000F_C35A);

      // 5: asynchronous reset in the middle of a shift
      push_words(0, 24'h003CA5, 2);
      pulse_start(0);
      wait_bits(0, 3);
      #1 nrst = 1'b0;
      #1;
      chk("t5_async_reset",
          64'({ready_s[0], cdata_s[0], cen_s[0], busy_s[0], done_s[0], err_s[0]}), 64'd0);
      repeat (2) @(posedge clk);
      #2 nrst = 1'b1;
      push_words(0, 24'h00C33C, 2);
      pulse_start(0);
      wait_done(0, dc);
      chk("t5_reload_sequence", 64'(seq[0][15:0]), 64'h0000_0000_0000_C33C);

`ifdef CFG_CRC_EN
      // 6: check word against the serial CRC of 0x01 over 8 bits
      wq[2].push_back(8'h01);
      wq[2].push_back(8'h89);
      pulse_start(2);
      wait_done(2, dc);
      chk("t6_good_crc", 64'(err_s[2]), 64'd0);
      wq[2].push_back(8'h01);
      wq[2].push_back(8'h88);
      pulse_start(2);
      wait_done(2, dc);
      chk("t6_bad_crc", 64'(err_s[2]), 64'd1);
      chk("t6_bad_crc_done", 64'(done_s[2]), 64'd1);
`endif

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
